sdram_port_arbiter: RTL

SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

---
 rtl/sdram_arb_pkg.sv | 19 +
 rtl/sdram_port_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/sdram_arb_pkg.sv
`default_nettype none
// ============================================================================
// sdram_arb_pkg -- shared types and port indices for the SDRAM port arbiter
// Revision: 1.0
// ============================================================================
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic PORT_VIDEO = 1'b0;
    localparam logic PORT_CPU   = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// sdram_port_arbiter -- two-port (video/CPU) arbiter for a single-command
//                       SDRAM controller, video priority with CPU starvation guard
// Revision: 1.0
// ============================================================================
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W       = 24,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset_ni,

    input  logic                m0_req_i,
    input  logic                m0_we_i,
    input  logic [ADDR_W-1:0]   m0_addr_i,
    input  logic [DATA_W-1:0]   m0_wdata_i,
    input  logic [DATA_W/8-1:0] m0_wmask_i,
    output logic                m0_ack_o,
    output logic [DATA_W-1:0]   m0_rdata_o,

    input  logic                m1_req_i,
    input  logic                m1_we_i,
    input  logic [ADDR_W-1:0]   m1_addr_i,
    input  logic [DATA_W-1:0]   m1_wdata_i,
    input  logic [DATA_W/8-1:0] m1_wmask_i,
    output logic                m1_ack_o,
    output logic [DATA_W-1:0]   m1_rdata_o,

    output logic                s_valid_o,
    input  logic                s_ready_i,
    output logic                s_we_o,
    output logic [ADDR_W-1:0]   s_addr_o,
    output logic [DATA_W-1:0]   s_wdata_o,
    output logic [DATA_W/8-1:0] s_wmask_o,
    input  logic [DATA_W-1:0]   s_rdata_i,
    input  logic                s_rvalid_i,

    output logic                busy_o
);

    localparam int c_MASK_W = DATA_W / 8;
    localparam int c_CNT_W  = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(STARVE_LIMIT);

    state_t                state_q,     state_d;
    logic                  grant_q,     grant_d;
    logic [c_CNT_W-1:0]    starve_cnt_q, starve_cnt_d;
    logic                  s_valid_q,   s_valid_d;
    logic                  s_we_q,      s_we_d;
    logic [ADDR_W-1:0]     s_addr_q,    s_addr_d;
    logic [DATA_W-1:0]     s_wdata_q,   s_wdata_d;
    logic [c_MASK_W-1:0]   s_wmask_q,   s_wmask_d;
    logic [DATA_W-1:0]     m0_rdata_q,  m0_rdata_d;
    logic [DATA_W-1:0]     m1_rdata_q,  m1_rdata_d;
    logic                  w_winner;

    // The "last grant was video" term only matters for STARVE_LIMIT == 0, where
    // it turns the always-saturated counter into strict alternation.
    function automatic logic pick_winner(input logic req0, input logic req1,
                                         input logic [c_CNT_W-1:0] cnt,
                                         input logic last_grant);
        if (req1 && (!req0 || (cnt == c_LIMIT && last_grant == PORT_VIDEO)))
            return PORT_CPU;
        return PORT_VIDEO;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_ni) begin
            state_q      <= IDLE;
            grant_q      <= PORT_VIDEO;
            starve_cnt_q <= '0;
            s_valid_q    <= 1'b0;
            s_we_q       <= 1'b0;
            s_addr_q     <= '0;
            s_wdata_q    <= '0;
            s_wmask_q    <= '0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            starve_cnt_q <= starve_cnt_d;
            s_valid_q    <= s_valid_d;
            s_we_q       <= s_we_d;
            s_addr_q     <= s_addr_d;
            s_wdata_q    <= s_wdata_d;
            s_wmask_q    <= s_wmask_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        starve_cnt_d = starve_cnt_q;
        s_valid_d    = s_valid_q;
        s_we_d       = s_we_q;
        s_addr_d     = s_addr_q;
        s_wdata_d    = s_wdata_q;
        s_wmask_d    = s_wmask_q;
        m0_rdata_d   = m0_rdata_q;
        m1_rdata_d   = m1_rdata_q;
        w_winner     = pick_winner(m0_req_i, m1_req_i, starve_cnt_q, grant_q);

        unique case (state_q)
            IDLE: begin
                if (m0_req_i || m1_req_i) begin
                    grant_d   = w_winner;
                    s_valid_d = 1'b1;
                    state_d   = ISSUE;
                    if (w_winner == PORT_CPU) begin
                        s_we_d       = m1_we_i;
                        s_addr_d     = m1_addr_i;
                        s_wdata_d    = m1_wdata_i;
                        s_wmask_d    = m1_wmask_i;
                        starve_cnt_d = '0;
                    end else begin
                        s_we_d    = m0_we_i;
                        s_addr_d  = m0_addr_i;
                        s_wdata_d = m0_wdata_i;
                        s_wmask_d = m0_wmask_i;
                        if (!m1_req_i)
                            starve_cnt_d = '0;
                        else if (starve_cnt_q != c_LIMIT)
                            starve_cnt_d = starve_cnt_q + c_CNT_W'(1);
                    end
                end
            end
            ISSUE: begin
                if (s_ready_i) begin
                    s_valid_d = 1'b0;
                    state_d   = s_we_q ? DONE : WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (s_rvalid_i) begin
                    if (grant_q == PORT_CPU)
                        m1_rdata_d = s_rdata_i;
                    else
                        m0_rdata_d = s_rdata_i;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign s_valid_o  = s_valid_q;
    assign s_we_o     = s_we_q;
    assign s_addr_o   = s_addr_q;
    assign s_wdata_o  = s_wdata_q;
    assign s_wmask_o  = s_wmask_q;
    assign m0_rdata_o = m0_rdata_q;
    assign m1_rdata_o = m1_rdata_q;
    assign m0_ack_o   = (state_q == DONE) && (grant_q == PORT_VIDEO);
    assign m1_ack_o   = (state_q == DONE) && (grant_q == PORT_CPU);
    assign busy_o     = (state_q != IDLE);

endmodule
`default_nettype wire
